// File: rtl/hamming_stream_codec_if.sv
// ---------------------------------------------------------------------------
// hamming_stream_codec_if
//
// Streaming bus of the Hamming codec: an input channel (valid/ready + mode +
// data) and an output channel (valid/ready + mode + data + decode status).
//
// Parameters:
//   DATA_W  data bits per word; PAR_W and CODE_W are derived from it exactly
//           as inside the codec so both sides agree on widths.
// Optional feature macro: HAMMING_SECDED_EN widens CODE_W by one bit.
//
// Modports:
//   master  producer/consumer side (drives in_*, out_ready)
//   slave   codec side (drives in_ready, out_*)
// ---------------------------------------------------------------------------
interface hamming_stream_codec_if #(
  parameter int DATA_W = 4
);

  // Smallest r with 2^r >= DATA_W + r + 1.
  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int PAR_W = calc_par_w(DATA_W);
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = DATA_W + PAR_W + 1;
`else
  localparam int CODE_W = DATA_W + PAR_W;
`endif

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_mode;
  logic [CODE_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_err_single;
  logic              out_err_uncorr;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_syndrome,
           out_err_single, out_err_uncorr
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_syndrome,
           out_err_single, out_err_uncorr
  );

endinterface

// File: rtl/hamming_stream_codec.sv
// ---------------------------------------------------------------------------
// hamming_stream_codec
//
// Two-stage pipelined Hamming encoder/decoder with valid/ready streaming and
// saturating error-statistics counters.
//   S1: registers the incoming word; parity (encode) and syndrome (decode)
//       are computed from the S1 register.
//   S2: single-bit correction, drives the registered outputs.
// A word accepted in cycle N is presented in cycle N+2 when not stalled.
//
// Parameters:
//   DATA_W  data bits per word (1..57)
//   CNT_W   width of each error counter
// Optional feature macro: HAMMING_SECDED_EN adds an overall-parity bit at the
// codeword MSB and enables double-error detection.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   bus            streaming bus (slave modport): in_* / out_* channels
//   clr_cnt        synchronous clear of both counters (wins over increment)
//   cnt_corrected  saturating count of corrected words
//   cnt_uncorr     saturating count of uncorrectable words
// ---------------------------------------------------------------------------
module hamming_stream_codec #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hamming_stream_codec_if.slave bus,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      cnt_corrected,
  output logic [CNT_W-1:0]      cnt_uncorr
);

  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int PAR_W = calc_par_w(DATA_W);
  // Hamming positions 1..HAM_W, excluding any overall-parity bit.
  localparam int HAM_W = DATA_W + PAR_W;
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = HAM_W + 1;
`else
  localparam int CODE_W = HAM_W;
`endif

  logic              s1_valid_q, s1_valid_d;
  logic              s1_mode_q, s1_mode_d;
  logic [CODE_W-1:0] s1_data_q, s1_data_d;

  logic              out_valid_q, out_valid_d;
  logic              out_mode_q, out_mode_d;
  logic [CODE_W-1:0] out_data_q, out_data_d;
  logic [PAR_W-1:0]  out_syn_q, out_syn_d;
  logic              out_single_q, out_single_d;
  logic              out_uncorr_q, out_uncorr_d;

  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0]  cnt_unc_q, cnt_unc_d;

  logic              en;
  logic              xfer_out;
  logic [CODE_W-1:0] enc_cw;
  logic [PAR_W-1:0]  syn;
  logic [CODE_W-1:0] flip_mask;
  logic              syn_in_range;
  logic [CODE_W-1:0] fixed_cw;
  logic [DATA_W-1:0] dec_data;
  logic              dec_single;
  logic              dec_uncorr;
`ifdef HAMMING_SECDED_EN
  logic              pa;
`endif

  assign en            = !out_valid_q || bus.out_ready;
  assign xfer_out      = out_valid_q && bus.out_ready;
  assign bus.in_ready  = rst_n && en;

  assign bus.out_valid      = out_valid_q;
  assign bus.out_mode       = out_mode_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_syndrome   = out_syn_q;
  assign bus.out_err_single = out_single_q;
  assign bus.out_err_uncorr = out_uncorr_q;
  assign cnt_corrected      = cnt_corr_q;
  assign cnt_uncorr         = cnt_unc_q;

  // Encoder: scatter data bits into the non-power-of-two positions, then fill
  // each parity position 2^j. Parity positions are still zero while their
  // group is summed, and no other parity position lies in group j.
  always_comb begin : encode_c
    int  k;
    logic par;
    enc_cw = '0;
    k      = 0;
    par    = 1'b0;
    for (int p = 1; p <= HAM_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        enc_cw[p-1] = s1_data_q[k];
        k++;
      end
    end
    for (int j = 0; j < PAR_W; j++) begin
      par = 1'b0;
      for (int p = 1; p <= HAM_W; p++) begin
        if (((p >> j) & 1) != 0) par = par ^ enc_cw[p-1];
      end
      enc_cw[(1 << j) - 1] = par;
    end
`ifdef HAMMING_SECDED_EN
    enc_cw[CODE_W-1] = ^enc_cw[HAM_W-1:0];
`endif
  end

  // Syndrome over the Hamming positions of the received word.
  always_comb begin : syndrome_c
    syn = '0;
    for (int j = 0; j < PAR_W; j++) begin
      for (int p = 1; p <= HAM_W; p++) begin
        if (((p >> j) & 1) != 0) syn[j] = syn[j] ^ s1_data_q[p-1];
      end
    end
  end

`ifdef HAMMING_SECDED_EN
  assign pa = ^s1_data_q;
`endif

  // One-hot mask of the bit the syndrome points at; empty when the syndrome
  // is zero or names a position beyond the codeword.
  always_comb begin : flip_mask_c
    flip_mask = '0;
    for (int b = 0; b < CODE_W; b++) begin
      if ((syn != '0) && (syn == PAR_W'(b + 1))) flip_mask[b] = 1'b1;
    end
  end

  assign syn_in_range = |flip_mask;

  always_comb begin : correct_c
    int k;
    fixed_cw   = s1_data_q;
    dec_single = 1'b0;
    dec_uncorr = 1'b0;
    dec_data   = '0;
    k          = 0;
`ifdef HAMMING_SECDED_EN
    // Zero syndrome with odd overall parity: only the overall-parity bit is
    // wrong, so the data is already good. Nonzero syndrome with even parity
    // means two flipped bits.
    if (syn == '0) begin
      dec_single = pa;
    end else if (pa) begin
      if (syn_in_range) begin
        fixed_cw   = s1_data_q ^ flip_mask;
        dec_single = 1'b1;
      end else begin
        dec_uncorr = 1'b1;
      end
    end else begin
      dec_uncorr = 1'b1;
    end
`else
    if (syn != '0) begin
      if (syn_in_range) begin
        fixed_cw   = s1_data_q ^ flip_mask;
        dec_single = 1'b1;
      end else begin
        dec_uncorr = 1'b1;
      end
    end
`endif
    for (int p = 1; p <= HAM_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        dec_data[k] = fixed_cw[p-1];
        k++;
      end
    end
  end

  // Pipeline advance: every stage moves together only when the output
  // register is free or being drained, so a stall freezes all out_*.
  always_comb begin : next_c
    s1_valid_d   = s1_valid_q;
    s1_mode_d    = s1_mode_q;
    s1_data_d    = s1_data_q;
    out_valid_d  = out_valid_q;
    out_mode_d   = out_mode_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_single_d = out_single_q;
    out_uncorr_d = out_uncorr_q;
    if (en) begin
      s1_valid_d  = bus.in_valid;
      s1_mode_d   = bus.in_mode;
      s1_data_d   = bus.in_data;
      out_valid_d = s1_valid_q;
      out_mode_d  = s1_mode_q;
      if (s1_mode_q) begin
        out_data_d   = {{(CODE_W-DATA_W){1'b0}}, dec_data};
        out_syn_d    = syn;
        out_single_d = dec_single;
        out_uncorr_d = dec_uncorr;
      end else begin
        out_data_d   = enc_cw;
        out_syn_d    = '0;
        out_single_d = 1'b0;
        out_uncorr_d = 1'b0;
      end
    end
  end

  // Counters step on a decode-mode output transfer carrying the matching
  // flag; clear takes priority and they stick at all-ones.
  always_comb begin : counters_c
    cnt_corr_d = cnt_corr_q;
    cnt_unc_d  = cnt_unc_q;
    if (clr_cnt) begin
      cnt_corr_d = '0;
      cnt_unc_d  = '0;
    end else if (xfer_out && out_mode_q) begin
      if (out_single_q && (cnt_corr_q != {CNT_W{1'b1}})) cnt_corr_d = cnt_corr_q + CNT_W'(1);
      if (out_uncorr_q && (cnt_unc_q != {CNT_W{1'b1}}))  cnt_unc_d  = cnt_unc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_data_q    <= '0;
      out_valid_q  <= 1'b0;
      out_mode_q   <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_single_q <= 1'b0;
      out_uncorr_q <= 1'b0;
      cnt_corr_q   <= '0;
      cnt_unc_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_data_q    <= s1_data_d;
      out_valid_q  <= out_valid_d;
      out_mode_q   <= out_mode_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_single_q <= out_single_d;
      out_uncorr_q <= out_uncorr_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_unc_q    <= cnt_unc_d;
    end
  end

endmodule

// File: tb/tb_hamming_stream_codec.sv
// ---------------------------------------------------------------------------
// tb_hamming_stream_codec
//
// Scoreboard bench for hamming_stream_codec (DATA_W=4, CNT_W=2 so counter
// saturation is reachable). Stimulus pushes the reference-model result into
// a queue when a word is accepted; a negedge monitor pops and compares on
// every output transfer, tracks counters, and checks that stalled outputs
// hold. Works with or without HAMMING_SECDED_EN.
// ---------------------------------------------------------------------------
module tb_hamming_stream_codec;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;

  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int PAR_W = calc_par_w(DATA_W);
  localparam int HAM_W = DATA_W + PAR_W;
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = HAM_W + 1;
`else
  localparam int CODE_W = HAM_W;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              mode;
    logic [CODE_W-1:0] data;
    logic [PAR_W-1:0]  syn;
    logic              single;
    logic              uncorr;
  } exp_t;

  typedef enum int {RDY_HIGH, RDY_RAND, RDY_LOW} rdy_mode_e;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt_corrected;
  logic [CNT_W-1:0] cnt_uncorr;

  rdy_mode_e ready_mode = RDY_HIGH;
  logic      clr_force  = 1'b0;
  logic      clr_rand   = 1'b0;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   m_corr = 0;
  int   m_unc  = 0;
  logic prev_stall = 1'b0;
  exp_t held;

  hamming_stream_codec_if #(.DATA_W(DATA_W)) bus ();

  hamming_stream_codec #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .clr_cnt       (clr_cnt),
    .cnt_corrected (cnt_corrected),
    .cnt_uncorr    (cnt_uncorr)
  );

  always #5 clk = ~clk;

  // Reference model: a valid codeword is one whose set-bit positions XOR to
  // zero, so parity bits are chosen to cancel the data positions' XOR sum.
  function automatic logic [CODE_W-1:0] model_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    int k;
    int acc;
    cw  = '0;
    k   = 0;
    acc = 0;
    for (int p = 1; p <= HAM_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= HAM_W; p++) if (cw[p-1]) acc = acc ^ p;
    for (int j = 0; j < PAR_W; j++) if (((acc >> j) & 1) != 0) cw[(1 << j) - 1] = 1'b1;
`ifdef HAMMING_SECDED_EN
    cw[CODE_W-1] = ^cw[HAM_W-1:0];
`endif
    return cw;
  endfunction

  function automatic exp_t model_decode(input logic [CODE_W-1:0] cw);
    exp_t e;
    logic [CODE_W-1:0] fixed;
    logic [DATA_W-1:0] d;
    int acc;
    int k;
    logic pa;
    acc   = 0;
    k     = 0;
    d     = '0;
    fixed = cw;
    pa    = ^cw;
    e     = '0;
    e.mode = 1'b1;
    for (int p = 1; p <= HAM_W; p++) if (cw[p-1]) acc = acc ^ p;
`ifdef HAMMING_SECDED_EN
    if (acc == 0) begin
      e.single = pa;
    end else if (pa) begin
      if (acc <= CODE_W) begin
        fixed[acc-1] = ~fixed[acc-1];
        e.single = 1'b1;
      end else begin
        e.uncorr = 1'b1;
      end
    end else begin
      e.uncorr = 1'b1;
    end
`else
    if (acc != 0) begin
      if (acc <= CODE_W) begin
        fixed[acc-1] = ~fixed[acc-1];
        e.single = 1'b1;
      end else begin
        e.uncorr = 1'b1;
      end
    end
`endif
    for (int p = 1; p <= HAM_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = fixed[p-1];
        k++;
      end
    end
    e.data = CODE_W'(d);
    e.syn  = PAR_W'(acc);
    return e;
  endfunction

  function automatic exp_t model_expect(input logic mode, input logic [CODE_W-1:0] din);
    exp_t e;
    if (mode) begin
      e = model_decode(din);
    end else begin
      e      = '0;
      e.data = model_encode(din[DATA_W-1:0]);
    end
    return e;
  endfunction

  function automatic logic [CODE_W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CODE_W-1:0];
  endfunction

  function automatic logic [CODE_W-1:0] single_err_word();
    logic [CODE_W-1:0] cw;
    int idx;
    cw  = model_encode(DATA_W'($urandom()));
    idx = $urandom_range(0, HAM_W - 1);
    cw[idx] = ~cw[idx];
    return cw;
  endfunction

  function automatic void checkValue(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void failEvent(input string name, input string got, input string want);
    total++;
    bad++;
    $display("[TB] FAIL %s: got=%s expected=%s at %0t", name, got, want, $time);
  endfunction

  // Consumer ready and counter clear are driven from one place, a little
  // after the rising edge, so directed code only selects the behaviour.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      RDY_HIGH: bus.out_ready = 1'b1;
      RDY_LOW:  bus.out_ready = 1'b0;
      default:  bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
    clr_cnt = clr_force || (clr_rand && ($urandom_range(0, 15) == 0));
  end

  // Drives one word and waits (bounded) for acceptance; the expectation is
  // queued in the same cycle the word is taken.
  task automatic applyStimulus(input logic mode, input logic [CODE_W-1:0] din, input exp_t e);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_data  = din;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    if (!acc) failEvent("accept_timeout", "not accepted", "accepted within 200 cycles");
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    checkValue("cnt_corrected", 64'(cnt_corrected), 64'(m_corr));
    checkValue("cnt_uncorr", 64'(cnt_uncorr), 64'(m_unc));
    if (!rst_n) begin
      checkValue("in_ready_in_reset", 64'(bus.in_ready), 64'(0));
      exp_q.delete();
      m_corr     = 0;
      m_unc      = 0;
      prev_stall = 1'b0;
      return;
    end
    if (bus.out_ready) checkValue("in_ready_open", 64'(bus.in_ready), 64'(1));
    if (prev_stall) begin
      checkValue("hold_valid", 64'(bus.out_valid), 64'(1));
      checkValue("hold_mode", 64'(bus.out_mode), 64'(held.mode));
      checkValue("hold_data", 64'(bus.out_data), 64'(held.data));
      checkValue("hold_syn", 64'(bus.out_syndrome), 64'(held.syn));
      checkValue("hold_single", 64'(bus.out_err_single), 64'(held.single));
      checkValue("hold_uncorr", 64'(bus.out_err_uncorr), 64'(held.uncorr));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        failEvent("stale_output", "output transfer", "no output pending");
      end else begin
        e = exp_q.pop_front();
        checkValue("out_mode", 64'(bus.out_mode), 64'(e.mode));
        checkValue("out_data", 64'(bus.out_data), 64'(e.data));
        checkValue("out_syndrome", 64'(bus.out_syndrome), 64'(e.syn));
        checkValue("out_err_single", 64'(bus.out_err_single), 64'(e.single));
        checkValue("out_err_uncorr", 64'(bus.out_err_uncorr), 64'(e.uncorr));
        if (e.mode && e.single && m_corr < CNT_MAX) m_corr++;
        if (e.mode && e.uncorr && m_unc < CNT_MAX) m_unc++;
      end
    end
    if (clr_cnt) begin
      m_corr = 0;
      m_unc  = 0;
    end
    prev_stall  = bus.out_valid && !bus.out_ready;
    held.mode   = bus.out_mode;
    held.data   = bus.out_data;
    held.syn    = bus.out_syndrome;
    held.single = bus.out_err_single;
    held.uncorr = bus.out_err_uncorr;
  endtask

  always @(negedge clk) checkOutput();

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    logic [CODE_W-1:0] din;
    logic mode;
    int kind;
    int idx;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mode  = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Encode 0101 with an empty pipeline: visible exactly two cycles later.
    e = '0;
`ifdef HAMMING_SECDED_EN
    e.data = CODE_W'(8'b00101101);
`else
    e.data = CODE_W'(7'b0101101);
`endif
    din = CODE_W'(4'b0101);
    applyStimulus(1'b0, din, e);
    checkValue("latency_n1_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
    checkValue("latency_n2_valid", 64'(bus.out_valid), 64'(1));
    checkValue("encode_0101", 64'(bus.out_data), 64'(e.data));
    waitCycles(2);

    // Single error at bit 5.
    e        = '0;
    e.mode   = 1'b1;
    e.data   = CODE_W'(4'b0101);
    e.syn    = PAR_W'(6);
    e.single = 1'b1;
`ifdef HAMMING_SECDED_EN
    din = CODE_W'(8'b00001101);
`else
    din = CODE_W'(7'b0001101);
`endif
    applyStimulus(1'b1, din, e);
    waitCycles(3);
    checkValue("cnt_corr_after_single", 64'(cnt_corrected), 64'(1));

`ifdef HAMMING_SECDED_EN
    // Double error in bits 0 and 1.
    e        = '0;
    e.mode   = 1'b1;
    e.data   = CODE_W'(4'b0101);
    e.syn    = PAR_W'(3);
    e.uncorr = 1'b1;
    applyStimulus(1'b1, CODE_W'(8'b00101110), e);
    waitCycles(3);
    checkValue("cnt_uncorr_after_double", 64'(cnt_uncorr), 64'(1));
`endif

    // Back-to-back stream with a three-cycle consumer stall mid-stream.
    fork
      begin : stream_drv
        logic [CODE_W-1:0] sd;
        logic sm;
        for (int i = 0; i < 4; i++) begin
          sm = $urandom_range(0, 1);
          sd = sm ? single_err_word() : rand_word();
          applyStimulus(sm, sd, model_expect(sm, sd));
        end
      end
      begin : stall_ctl
        repeat (3) @(posedge clk);
        ready_mode = RDY_LOW;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkValue("stall_in_ready", 64'(bus.in_ready), 64'(0));
          checkValue("stall_out_valid", 64'(bus.out_valid), 64'(1));
          @(posedge clk);
        end
        ready_mode = RDY_HIGH;
      end
    join
    waitCycles(4);
    checkValue("stream_drained", 64'(exp_q.size()), 64'(0));

    // Counter saturation and clear-over-increment priority.
    @(posedge clk); #1; clr_force = 1'b1;
    @(posedge clk); #1; clr_force = 1'b0;
    checkValue("cnt_after_clear", 64'(cnt_corrected), 64'(0));
    for (int i = 0; i < 4; i++) begin
      din = single_err_word();
      applyStimulus(1'b1, din, model_expect(1'b1, din));
    end
    waitCycles(3);
    checkValue("cnt_saturated", 64'(cnt_corrected), 64'(CNT_MAX));
    din = single_err_word();
    applyStimulus(1'b1, din, model_expect(1'b1, din));
    @(posedge clk); #1; clr_force = 1'b1;
    @(posedge clk); #1; clr_force = 1'b0;
    checkValue("clr_beats_increment", 64'(cnt_corrected), 64'(0));
    waitCycles(2);

    // Reset with two words in flight behind a stalled consumer.
    din = single_err_word();
    applyStimulus(1'b1, din, model_expect(1'b1, din));
    waitCycles(3);
    ready_mode = RDY_LOW;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      din = single_err_word();
      applyStimulus(1'b1, din, model_expect(1'b1, din));
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    ready_mode = RDY_HIGH;
    checkValue("reset_out_valid", 64'(bus.out_valid), 64'(0));
    checkValue("reset_cnt_corr", 64'(cnt_corrected), 64'(0));
    checkValue("reset_cnt_unc", 64'(cnt_uncorr), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkValue("no_stale_after_reset", 64'(bus.out_valid), 64'(0));
    end

    // Randomised traffic: clean, single, double and arbitrary codewords.
    ready_mode = RDY_RAND;
    clr_rand   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      if (!mode || kind == 3) begin
        din = rand_word();
      end else begin
        din = model_encode(DATA_W'($urandom()));
        if (kind >= 1) begin
          idx = $urandom_range(0, CODE_W - 1);
          din[idx] = ~din[idx];
        end
        if (kind == 2) begin
          idx = (idx + $urandom_range(1, CODE_W - 1)) % CODE_W;
          din[idx] = ~din[idx];
        end
      end
      applyStimulus(mode, din, model_expect(mode, din));
      if ($urandom_range(0, 4) == 0) waitCycles($urandom_range(1, 3));
    end
    ready_mode = RDY_HIGH;
    clr_rand   = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    waitCycles(2);
    checkValue("final_drain", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_stream_codec.md
Name: hamming_stream_codec

Overview:
- Parametrised, pipelined Hamming codec. Generalises the fixed (7,4) combinational encoder to any data width, adds a decode/correct mode and valid/ready streaming.
- Each transaction carries a mode bit: encode (data to codeword) or decode (codeword to corrected data plus error status).
- Sits between a producer and a consumer that both use valid/ready. Keeps saturating error-statistics counters.

Parameters:
- DATA_W, 4, data bits per word, range 1..57.
- CNT_W, 16, width of each error counter.
- PAR_W, derived localparam, not overridable: smallest r with 2^r >= DATA_W+r+1. Equals 3 for DATA_W=4.
- CODE_W, derived localparam: DATA_W+PAR_W, plus 1 when HAMMING_SECDED_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_mode  in  1  0 = encode, 1 = decode.
- in_data  in  CODE_W  encode: data in [DATA_W-1:0], upper bits ignored. Decode: received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_mode  out  1  mode of the result being presented.
- out_data  out  CODE_W  encode: codeword. Decode: corrected data in [DATA_W-1:0], upper bits 0.
- out_syndrome  out  PAR_W  decode syndrome, 0 in encode mode.
- out_err_single  out  1  single error detected and corrected.
- out_err_uncorr  out  1  uncorrectable error; data passed through uncorrected.
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_corrected  out  CNT_W  count of corrected words, saturating.
- cnt_uncorr  out  CNT_W  count of uncorrectable words, saturating.

Behaviour:
- Codeword layout:
  - Bit index k holds Hamming position k+1, for positions 1..DATA_W+PAR_W.
  - Parity bits sit at power-of-two positions. Parity bit at position 2^j = XOR of all positions whose index has bit j set.
  - Data bits d0, d1, ... fill the remaining positions in ascending order.
- Pipeline has 2 stages:
  - S1 registers the input and computes parity/syndrome.
  - S2 does correction and drives the output registers.
  - Latency: a word accepted in cycle N appears on out_* in cycle N+2 when unstalled.
- Handshake:
  - en = !out_valid || out_ready. in_ready = en.
  - Transfer in = in_valid && in_ready. Transfer out = out_valid && out_ready.
  - All stages advance only when en=1. When out_valid && !out_ready, every out_* signal holds stable.
  - Throughput is 1 word/cycle with out_ready held high.
- Decode (SEC only, macro undefined), syndrome s:
  - s=0: no error, no flags set.
  - 1 <= s <= CODE_W: flip bit s-1, assert out_err_single.
  - s > CODE_W: assert out_err_uncorr, no flip.
- Encode: out_err_single = out_err_uncorr = 0. out_syndrome = 0.
- Counters:
  - Increment only on a transfer out in decode mode with the matching flag set. Saturate at 2^CNT_W-1.
  - clr_cnt has priority over a same-cycle increment; the counter becomes 0.
- Reset (rst_n=0 at a clock edge), including mid-operation:
  - Both stage valids clear, so in-flight words are dropped.
  - out_valid=0, out_data=0, all flags=0, out_syndrome=0, out_mode=0, both counters=0.
  - in_ready=0 while rst_n=0, and 1 on the first cycle after release.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- Defined:
  - Adds an overall-parity bit at index CODE_W-1 (MSB), equal to the XOR of all other codeword bits.
  - Decode uses s and pa = XOR of all CODE_W received bits:
    - s=0, pa=0: no error.
    - s=0, pa=1: single error in the overall-parity bit. Set err_single; data unchanged.
    - s!=0, pa=1: single error. Correct as in SEC; s out of range gives err_uncorr.
    - s!=0, pa=0: double error. Set err_uncorr; data uncorrected.
- Undefined: plain SEC as above, and CODE_W excludes the extra bit.

Test Plan:
- Encode, DATA_W=4, in_data=0101, out_ready=1 -> two cycles later out_data=7'b0101101, flags 0. With macro: 8'b00101101.
- Decode 7'b0001101 (bit 5 flipped) -> out_data=0101, out_syndrome=6, out_err_single=1, cnt_corrected=1.
- Macro defined, decode 8'b00101110 (bits 0 and 1 flipped) -> out_err_uncorr=1, out_err_single=0, cnt_uncorr=1.
- Back-to-back stream of 4 words with out_ready low for 3 cycles mid-stream -> out_* held stable while stalled, in_ready=0 during stall, no word lost or duplicated, order preserved.
- Preload cnt_corrected to 2^CNT_W-1 with CNT_W=2 (3 errored words), then send a 4th errored word -> counter stays 3. Assert clr_cnt in the same cycle as an increment -> counter 0.
- Assert rst_n=0 for 1 cycle with 2 words in flight -> out_valid=0 next cycle, counters 0, and no stale output appears afterwards.
